core_bus_master: RTL and testbench
==================================

# core_bus_master

Core-side AXI4-Lite initiator for the ClangPU core. It converts single-beat core memory requests (load/store) into AXI4-Lite write or read transactions on an M_AXI port, then returns the read data and response status to the core. It mirrors the slave-side controller: the core drives transactions out onto the PS/PL interconnect instead of being driven by it. One outstanding transaction at a time, with a response timeout so a dead slave cannot hang the core.

## Interface
Parameters:
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 supported.
- C_M_AXI_ADDR_WIDTH, 32, address width.
- TIMEOUT_CYCLES, 1024, cycles from acceptance to response before timeout; 0 disables the timeout.

Ports:
- CCLK  in  1  sole clock; core and M_AXI are both synchronous to it.
- CRST  in  1  reset, asynchronous, active-high.
- REQ  in  1  core request valid.
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  C_M_AXI_ADDR_WIDTH  byte address.
- REQ_WDATA  in  32  write data.
- REQ_WSTRB  in  4  byte enables for writes.
- REQ_READY  out  1  block idle; request accepted when REQ && REQ_READY.
- RSP_VALID  out  1  one-cycle pulse; response fields valid.
- RSP_RDATA  out  32  read data (held until next RSP_VALID).
- RSP_RESP  out  2  BRESP/RRESP as received; 2'b00 on timeout.
- RSP_TIMEOUT  out  1  response produced by timeout.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master signals, widths per parameters; AWPROT = ARPROT = 3'b000.

## Operation
- States: IDLE, WR_ADDR (AW and/or W pending), WR_RESP, RD_ADDR, RD_DATA, DRAIN.
- IDLE: REQ_READY=1. On acceptance, register addr/data/strb/we; go to WR_ADDR (write) or RD_ADDR (read).
- WR_ADDR: AWVALID and WVALID both asserted from the first cycle; each drops independently after its own handshake; AW and W may complete in either order or the same cycle. When both are done, go to WR_RESP.
- WR_RESP: BREADY=1. On BVALID: RSP_VALID=1, RSP_RESP=BRESP; go to IDLE.
- RD_ADDR: ARVALID=1 until ARREADY; then RD_DATA.
- RD_DATA: RREADY=1. On RVALID: RSP_RDATA=RDATA, RSP_RESP=RRESP, RSP_VALID=1; go to IDLE.
- Timeout counter: cleared on acceptance; increments every cycle outside IDLE/DRAIN. When it reaches TIMEOUT_CYCLES: RSP_VALID=1, RSP_TIMEOUT=1, RSP_RESP=2'b00, RSP_RDATA unchanged; go to DRAIN.
- DRAIN: finish the abandoned transaction silently. Pending VALIDs stay high until their handshake (AXI forbids withdrawing them), and BREADY/RREADY are asserted. When the B or R beat is consumed, go to IDLE. REQ_READY stays 0 throughout DRAIN; no RSP_VALID is produced.
- Requests arriving outside IDLE are ignored; the core must hold REQ until it is accepted.
- Reset values: REQ_READY=1 (state IDLE). RSP_VALID, RSP_TIMEOUT, all M_AXI VALID/READY = 0. RSP_RDATA, RSP_RESP, and M_AXI address/data = 0.
- Reset mid-transaction: all outputs go to reset values immediately. The interconnect shares CRST, so the abandoned handshake is acceptable.

## Timing
- All outputs are registered; no combinational path from M_AXI inputs to M_AXI outputs.
- Accept at edge 0; AWVALID/WVALID/ARVALID high from cycle 1.
- Write with zero-wait slave (AWREADY/WREADY high, BVALID one cycle after W): handshake in cycle 1, BVALID in cycle 2, RSP_VALID in cycle 3. REQ_READY=1 in cycle 3, so a back-to-back request can be accepted at the edge ending cycle 3.
- Read with zero-wait slave: ARREADY in cycle 1, RVALID in cycle 2, RSP_VALID in cycle 3.
- The timeout and the response handshake in the same cycle resolve as a normal response; the timeout loses.

## Test plan
- Write 0xDEADBEEF, WSTRB 4'b1111, to 0x4000_0010 with a zero-wait slave. Required: AW/W seen in cycle 1, RSP_VALID in cycle 3 with RSP_RESP=00 and RSP_TIMEOUT=0.
- Write where WREADY comes 3 cycles before AWREADY. Required: WVALID drops after its handshake, AWVALID held until AWREADY, exactly one B accepted, one RSP_VALID.
- Read 0x4000_0000 where the slave returns RDATA=0x12345678, RRESP=2'b10. Required: RSP_RDATA=0x12345678, RSP_RESP=10, RSP_TIMEOUT=0.
- TIMEOUT_CYCLES=8, read with ARREADY never asserted for 20 cycles, then accepted with RVALID. Required: RSP_TIMEOUT pulse at acceptance+8, ARVALID held, REQ_READY=0 until R consumed, no second RSP_VALID.
- Assert CRST while in WR_RESP. Required: BREADY, RSP_VALID=0 and REQ_READY=1 immediately, without waiting for CCLK; a new read after reset completes normally.
- Back-to-back write then read, with REQ held high. Required: second acceptance on the RSP_VALID cycle of the first; two RSP_VALID pulses 3 cycles apart.

Source files
------------

// File: rtl/core_bus_master_if.sv
// AXI4-Lite bus between the ClangPU core initiator and the PS/PL interconnect.
// The master modport is the core side; the slave modport is the interconnect side.
interface core_bus_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWPROT, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/core_bus_master.sv
// Core-side AXI4-Lite initiator: one outstanding single-beat load/store at a time,
// with a response timeout that abandons the core request and drains the bus silently.
module core_bus_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            CCLK,
  input  logic                            CRST,
  input  logic                            REQ,
  input  logic                            REQ_WE,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   REQ_WDATA,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] REQ_WSTRB,
  output logic                            REQ_READY,
  output logic                            RSP_VALID,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]                      RSP_RESP,
  output logic                            RSP_TIMEOUT,
  core_bus_master_if.master               M_AXI
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_ADDR = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;

  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

  logic [2:0]                            state;
  logic                                  we_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]         addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]         wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]       wstrb_q;
  logic                                  aw_valid;
  logic                                  w_valid;
  logic                                  b_ready;
  logic                                  ar_valid;
  logic                                  r_ready;
  logic [31:0]                           tcnt;

  logic busy;
  logic aw_done;
  logic w_done;
  logic resp_hs;
  logic timeout_hit;
  logic go_drain;

  assign M_AXI.AWADDR  = addr_q;
  assign M_AXI.AWPROT  = '0;
  assign M_AXI.AWVALID = aw_valid;
  assign M_AXI.WDATA   = wdata_q;
  assign M_AXI.WSTRB   = wstrb_q;
  assign M_AXI.WVALID  = w_valid;
  assign M_AXI.BREADY  = b_ready;
  assign M_AXI.ARADDR  = addr_q;
  assign M_AXI.ARPROT  = '0;
  assign M_AXI.ARVALID = ar_valid;
  assign M_AXI.RREADY  = r_ready;

  // tcnt is 0 in the first cycle after acceptance; deciding at tcnt+2 lands the
  // registered timeout pulse exactly TIMEOUT_CYCLES cycles after acceptance.
  always_comb begin
    busy        = (state != S_IDLE) && (state != S_DRAIN);
    aw_done     = !aw_valid || M_AXI.AWREADY;
    w_done      = !w_valid  || M_AXI.WREADY;
    resp_hs     = ((state == S_WR_RESP) && M_AXI.BVALID) ||
                  ((state == S_RD_DATA) && M_AXI.RVALID);
    timeout_hit = (TO_LIMIT != '0) && ((tcnt + 32'd2) >= TO_LIMIT);
    go_drain    = busy && timeout_hit && !resp_hs;
  end

  always_ff @(posedge CCLK or posedge CRST) begin
    if (CRST) begin
      state       <= S_IDLE;
      REQ_READY   <= 1'b1;
      RSP_VALID   <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
      RSP_RDATA   <= '0;
      RSP_RESP    <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_valid    <= 1'b0;
      w_valid     <= 1'b0;
      b_ready     <= 1'b0;
      ar_valid    <= 1'b0;
      r_ready     <= 1'b0;
      tcnt        <= '0;
    end else begin
      RSP_VALID   <= 1'b0;
      RSP_TIMEOUT <= 1'b0;

      // Address/data channels retire on their own handshake in every non-idle
      // state, DRAIN included, since a raised VALID may not be withdrawn.
      if (state != S_IDLE) begin
        if (aw_valid && M_AXI.AWREADY) aw_valid <= 1'b0;
        if (w_valid  && M_AXI.WREADY)  w_valid  <= 1'b0;
        if (ar_valid && M_AXI.ARREADY) ar_valid <= 1'b0;
      end
      if (busy) tcnt <= tcnt + 32'd1;

      case (state)
        S_IDLE: begin
          if (REQ) begin
            REQ_READY <= 1'b0;
            we_q      <= REQ_WE;
            addr_q    <= REQ_ADDR;
            wdata_q   <= REQ_WDATA;
            wstrb_q   <= REQ_WSTRB;
            tcnt      <= '0;
            if (REQ_WE) begin
              aw_valid <= 1'b1;
              w_valid  <= 1'b1;
              state    <= S_WR_ADDR;
            end else begin
              ar_valid <= 1'b1;
              state    <= S_RD_ADDR;
            end
          end
        end
        S_WR_ADDR: begin
          if (aw_done && w_done) begin
            b_ready <= 1'b1;
            state   <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (M_AXI.BVALID) begin
            b_ready   <= 1'b0;
            RSP_VALID <= 1'b1;
            RSP_RESP  <= M_AXI.BRESP;
            REQ_READY <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_RD_ADDR: begin
          if (M_AXI.ARREADY) begin
            r_ready <= 1'b1;
            state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (M_AXI.RVALID) begin
            r_ready   <= 1'b0;
            RSP_VALID <= 1'b1;
            RSP_RDATA <= M_AXI.RDATA;
            RSP_RESP  <= M_AXI.RRESP;
            REQ_READY <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if ((b_ready && M_AXI.BVALID) || (r_ready && M_AXI.RVALID)) begin
            b_ready   <= 1'b0;
            r_ready   <= 1'b0;
            REQ_READY <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          REQ_READY <= 1'b1;
        end
      endcase

      // Timeout overrides whatever the busy state chose, except a response
      // handshake in the same cycle (excluded from go_drain).
      if (go_drain) begin
        state       <= S_DRAIN;
        RSP_VALID   <= 1'b1;
        RSP_TIMEOUT <= 1'b1;
        RSP_RESP    <= '0;
        b_ready     <= we_q;
        r_ready     <= !we_q;
      end
    end
  end

endmodule

// File: tb/tb_core_bus_master.sv
// Table-driven and randomized bench for core_bus_master with a delay-scheduled AXI slave;
// expected timing comes from a per-transaction latency formula, not from the RTL's states.
module tb_core_bus_master;

  localparam int unsigned T = 8;

  logic        CCLK = 1'b0;
  logic        CRST;
  logic        REQ;
  logic        REQ_WE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic [3:0]  REQ_WSTRB;
  logic        REQ_READY;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_RESP;
  logic        RSP_TIMEOUT;

  core_bus_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  core_bus_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .CCLK(CCLK), .CRST(CRST),
    .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .REQ_WSTRB(REQ_WSTRB), .REQ_READY(REQ_READY),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
    .RSP_TIMEOUT(RSP_TIMEOUT),
    .M_AXI(axi.master)
  );

  always #5 CCLK = ~CCLK;

  int unsigned cyc = 0;
  always @(posedge CCLK) cyc <= cyc + 1;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [31:0] model_rdata = '0;
  int unsigned prev_pulse_abs = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int unsigned da, dw, db, dr;   // slave delays: AW/AR ready, W ready, B after W/AW, R after AR
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        hold;             // keep REQ high after acceptance
    int unsigned gap;              // required distance to previous RSP_VALID, 0 = unchecked
    int unsigned exp_pulse;
    int unsigned exp_ready;
    logic        exp_to;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t dir[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic vec_t mkv(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int unsigned da, input int unsigned dw,
                               input int unsigned db, input int unsigned dr, input logic [1:0] resp,
                               input logic [31:0] rdata, input logic hold, input int unsigned gap,
                               input int unsigned ep, input int unsigned er, input logic eto,
                               input logic [1:0] eresp);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
    v.da = da; v.dw = dw; v.db = db; v.dr = dr;
    v.resp = resp; v.rdata = rdata; v.hold = hold; v.gap = gap;
    v.exp_pulse = ep; v.exp_ready = er; v.exp_to = eto; v.exp_resp = eresp;
    return v;
  endfunction

  // Reference latency: a response lands 3 cycles after acceptance plus slave stalls;
  // anything later than T is cut off by a timeout pulse at T, bus freed at the natural time.
  function automatic vec_t predict(input vec_t v);
    vec_t o = v;
    int unsigned r;
    r = v.we ? 3 + max2(v.da, v.dw) + v.db : 3 + v.da + v.dr;
    o.exp_ready = r;
    if (r > T) begin
      o.exp_pulse = T; o.exp_to = 1'b1; o.exp_resp = 2'b00;
    end else begin
      o.exp_pulse = r; o.exp_to = 1'b0; o.exp_resp = v.resp;
    end
    return o;
  endfunction

  // Entered after the negedge of an idle cycle; returns after the negedge of the cycle
  // in which REQ_READY comes back, so calls chain back-to-back.
  task automatic run_txn(input vec_t v);
    int unsigned aw_hs = 0, w_hs = 0, ar_hs = 0, bstart = 0, rstart = 0;
    int unsigned b_beats = 0, r_beats = 0, pulses = 0, ready_c = 0;
    int unsigned m, a, bfrom, rfrom;
    logic [31:0] exp_rd;
    m = 1 + max2(v.da, v.dw);
    a = 1 + v.da;
    bfrom = (v.exp_to && T < m + 1) ? T : m + 1;
    rfrom = (v.exp_to && T < a + 1) ? T : a + 1;
    exp_rd = (!v.we && !v.exp_to) ? v.rdata : model_rdata;

    check("req_ready_at_accept", REQ_READY, 1);
    REQ = 1'b1; REQ_WE = v.we; REQ_ADDR = v.addr; REQ_WDATA = v.wdata; REQ_WSTRB = v.wstrb;
    @(posedge CCLK); #1;
    if (!v.hold) REQ = 1'b0;

    for (int unsigned c = 1; c <= 60 && ready_c == 0; c++) begin
      axi.AWREADY = v.we && (c >= 1 + v.da) && (aw_hs == 0);
      axi.WREADY  = v.we && (c >= 1 + v.dw) && (w_hs == 0);
      axi.BVALID  = v.we && (bstart != 0) && (c >= bstart) && (b_beats == 0);
      axi.BRESP   = v.resp;
      axi.ARREADY = !v.we && (c >= 1 + v.da) && (ar_hs == 0);
      axi.RVALID  = !v.we && (rstart != 0) && (c >= rstart) && (r_beats == 0);
      axi.RDATA   = v.rdata;
      axi.RRESP   = v.resp;
      @(negedge CCLK);

      check("awvalid", axi.AWVALID, v.we && (c <= 1 + v.da));
      check("wvalid",  axi.WVALID,  v.we && (c <= 1 + v.dw));
      check("arvalid", axi.ARVALID, !v.we && (c <= 1 + v.da));
      check("bready",  axi.BREADY,  v.we && (c >= bfrom) && (c + 1 <= v.exp_ready));
      check("rready",  axi.RREADY,  !v.we && (c >= rfrom) && (c + 1 <= v.exp_ready));
      check("rsp_valid",   RSP_VALID,   c == v.exp_pulse);
      check("rsp_timeout", RSP_TIMEOUT, (c == v.exp_pulse) && v.exp_to);
      check("req_ready",   REQ_READY,   c >= v.exp_ready);

      if (axi.AWVALID && axi.AWREADY) begin
        aw_hs = c;
        check("awaddr", axi.AWADDR, v.addr);
        check("awprot", axi.AWPROT, 0);
      end
      if (axi.WVALID && axi.WREADY) begin
        w_hs = c;
        check("wdata", axi.WDATA, v.wdata);
        check("wstrb", axi.WSTRB, v.wstrb);
      end
      if (axi.ARVALID && axi.ARREADY) begin
        ar_hs = c;
        check("araddr", axi.ARADDR, v.addr);
        check("arprot", axi.ARPROT, 0);
      end
      if (axi.BVALID && axi.BREADY) b_beats++;
      if (axi.RVALID && axi.RREADY) r_beats++;
      if (aw_hs != 0 && w_hs != 0 && bstart == 0) bstart = max2(aw_hs, w_hs) + 1 + v.db;
      if (ar_hs != 0 && rstart == 0) rstart = ar_hs + 1 + v.dr;

      if (RSP_VALID) begin
        pulses++;
        check("rsp_resp", RSP_RESP, v.exp_resp);
        if (!v.we || v.exp_to) check("rsp_rdata", RSP_RDATA, exp_rd);
        if (v.gap != 0) check("rsp_gap", cyc - prev_pulse_abs, v.gap);
        prev_pulse_abs = cyc;
      end
      if (REQ_READY) ready_c = c;
      else begin
        @(posedge CCLK); #1;
      end
    end

    check("ready_cycle", ready_c, v.exp_ready);
    check("rsp_pulses", pulses, 1);
    check("b_beats", b_beats, v.we ? 1 : 0);
    check("r_beats", r_beats, v.we ? 0 : 1);
    model_rdata = exp_rd;
  endtask

  initial begin
    vec_t v;
    CRST = 1'b1; REQ = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_WSTRB = '0;
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0; axi.BRESP = '0;
    axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RDATA = '0; axi.RRESP = '0;

    //            we    addr          wdata         strb  da dw db dr resp   rdata         hold gap pulse ready to   eresp
    dir[0] = mkv(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0,        0, 0,  3,  3, 1'b0, 2'b00);
    dir[1] = mkv(1'b1, 32'h4000_0020, 32'hCAFE_F00D, 4'h3, 3, 0, 0, 0, 2'b01, 32'h0,        0, 0,  6,  6, 1'b0, 2'b01);
    dir[2] = mkv(1'b0, 32'h4000_0000, 32'h0,         4'h0, 0, 0, 0, 0, 2'b10, 32'h1234_5678, 0, 0,  3,  3, 1'b0, 2'b10);
    dir[3] = mkv(1'b0, 32'h4000_0040, 32'h0,         4'h0, 20,0, 0, 0, 2'b00, 32'hAAAA_5555, 0, 0,  8, 23, 1'b1, 2'b00);
    dir[4] = mkv(1'b1, 32'h4000_0044, 32'h0102_0304, 4'hC, 1, 0, 4, 0, 2'b11, 32'h0,        0, 0,  8,  8, 1'b0, 2'b11);
    dir[5] = mkv(1'b1, 32'h4000_0048, 32'h5555_AAAA, 4'h1, 2, 2, 4, 0, 2'b01, 32'h0,        0, 0,  8,  9, 1'b1, 2'b00);
    dir[6] = mkv(1'b0, 32'h4000_004C, 32'h0,         4'h0, 0, 0, 0, 5, 2'b01, 32'h0BAD_C0DE, 0, 0,  8,  8, 1'b0, 2'b01);
    dir[7] = mkv(1'b0, 32'h4000_0050, 32'h0,         4'h0, 1, 0, 0, 5, 2'b11, 32'hFFFF_0000, 0, 0,  8,  9, 1'b1, 2'b00);
    dir[8] = mkv(1'b1, 32'h4000_0054, 32'h1111_2222, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0,        1, 0,  3,  3, 1'b0, 2'b00);
    dir[9] = mkv(1'b0, 32'h4000_0058, 32'h0,         4'h0, 0, 0, 0, 0, 2'b00, 32'h8765_4321, 0, 3,  3,  3, 1'b0, 2'b00);

    #12;
    check("rst_req_ready", REQ_READY, 1);
    check("rst_rsp_valid", RSP_VALID, 0);
    check("rst_rsp_timeout", RSP_TIMEOUT, 0);
    check("rst_rsp_rdata", RSP_RDATA, 0);
    check("rst_rsp_resp", RSP_RESP, 0);
    check("rst_awvalid", axi.AWVALID, 0);
    check("rst_wvalid", axi.WVALID, 0);
    check("rst_bready", axi.BREADY, 0);
    check("rst_arvalid", axi.ARVALID, 0);
    check("rst_rready", axi.RREADY, 0);
    check("rst_awaddr", axi.AWADDR, 0);
    check("rst_wdata", axi.WDATA, 0);
    @(negedge CCLK);
    CRST = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(dir[i]);

    for (int i = 0; i < 40; i++) begin
      v.we = 1'($urandom_range(0, 1));
      v.addr = $urandom & 32'hFFFF_FFFC;
      v.wdata = $urandom;
      v.wstrb = 4'($urandom_range(1, 15));
      v.da = $urandom_range(0, 4); v.dw = $urandom_range(0, 4);
      v.db = $urandom_range(0, 4); v.dr = $urandom_range(0, 4);
      v.resp = 2'($urandom_range(0, 3));
      v.rdata = $urandom;
      v.hold = 1'($urandom_range(0, 1));
      v.gap = 0;
      run_txn(predict(v));
    end

    // Reset while waiting in the write-response phase
    REQ = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 32'h4000_0100; REQ_WDATA = 32'h0F0F_0F0F; REQ_WSTRB = 4'hF;
    @(posedge CCLK); #1;
    REQ = 1'b0; axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
    axi.BVALID = 1'b0; axi.ARREADY = 1'b0; axi.RVALID = 1'b0;
    @(posedge CCLK); #1;
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
    @(negedge CCLK);
    check("wr_resp_bready", axi.BREADY, 1);
    check("wr_resp_req_ready", REQ_READY, 0);
    #2 CRST = 1'b1;
    #1;
    check("async_rst_bready", axi.BREADY, 0);
    check("async_rst_req_ready", REQ_READY, 1);
    check("async_rst_rsp_valid", RSP_VALID, 0);
    check("async_rst_awvalid", axi.AWVALID, 0);
    check("async_rst_rdata", RSP_RDATA, 0);
    model_rdata = '0;
    @(negedge CCLK);
    CRST = 1'b0;
    run_txn(mkv(1'b0, 32'h4000_0200, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 32'h5A5A_A5A5, 0, 0, 3, 3, 1'b0, 2'b00));

    for (int i = 0; i < 4; i++) begin
      @(negedge CCLK);
      check("idle_rsp_valid", RSP_VALID, 0);
      check("idle_req_ready", REQ_READY, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
